// File: rtl/uart_cmd_parser_if.sv
// Byte-in / set-time-out bundle between the RX FIFO pop side and the watch core.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        o_set_valid;
  logic [23:0] o_set_data;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_busy;

  modport slave  (input  rx_data, rx_done,
                  output o_set_valid, o_set_data, o_err, o_err_code, o_busy);
  modport master (output rx_data, rx_done,
                  input  o_set_valid, o_set_data, o_err, o_err_code, o_busy);
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses "THH:MM:SS<CR|LF>" set-time lines from the UART RX byte stream and
// emits the time in packed watch format {hour, min, sec, msec=0}.
module uart_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_parser_if.slave  bus
);
  typedef enum logic [3:0] {IDLE, H10, H1, C1, M10, M1, C2, S10, S1, TERM, DISCARD} state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_tens;
  logic [4:0]       r_hour;
  logic [5:0]       r_min, r_sec;
  logic             r_set_valid, r_err;
  logic [23:0]      r_set_data;
  logic [1:0]       r_err_code;

  logic       w_digit, w_eol, w_tmo;
  logic       w_bad, w_range, w_tmo_err, w_commit;
  logic       w_ld_tens, w_ld_h, w_ld_m, w_ld_s;
  logic [6:0] w_val;

  assign w_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign w_eol   = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
  assign w_val   = 7'd10 * {3'd0, r_tens} + {3'd0, bus.rx_data[3:0]};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo   = !bus.rx_done && (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_next    = r_state;
    w_bad     = 1'b0;
    w_range   = 1'b0;
    w_tmo_err = 1'b0;
    w_commit  = 1'b0;
    w_ld_tens = 1'b0;
    w_ld_h    = 1'b0;
    w_ld_m    = 1'b0;
    w_ld_s    = 1'b0;
    if (bus.rx_done) begin
      unique case (r_state)
        IDLE:    if (bus.rx_data == 8'h54) w_next = H10;
        H10, M10, S10: begin
          if (!w_digit) w_bad = 1'b1;
          else begin
            w_ld_tens = 1'b1;
            w_next    = state_t'(r_state + 4'd1);
          end
        end
        H1: begin
          if (!w_digit)              w_bad   = 1'b1;
          else if (w_val >= 7'd24)   w_range = 1'b1;
          else begin w_ld_h = 1'b1; w_next = C1; end
        end
        M1: begin
          if (!w_digit)              w_bad   = 1'b1;
          else if (w_val >= 7'd60)   w_range = 1'b1;
          else begin w_ld_m = 1'b1; w_next = C2; end
        end
        S1: begin
          if (!w_digit)              w_bad   = 1'b1;
          else if (w_val >= 7'd60)   w_range = 1'b1;
          else begin w_ld_s = 1'b1; w_next = TERM; end
        end
        C1, C2: begin
          if (bus.rx_data != 8'h3A) w_bad = 1'b1;
          else w_next = state_t'(r_state + 4'd1);
        end
        TERM: begin
          if (!w_eol) w_bad = 1'b1;
          else begin w_commit = 1'b1; w_next = IDLE; end
        end
        DISCARD: if (w_eol) w_next = IDLE;
        default: w_next = IDLE;
      endcase
      if (w_bad || w_range) w_next = DISCARD;
    end else if (w_tmo) begin
      w_tmo_err = (r_state != DISCARD);
      w_next    = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_tens      <= '0;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_set_valid <= 1'b0;
      r_set_data  <= '0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state <= w_next;
      if (bus.rx_done || r_state == IDLE)        r_cnt <= '0;
      else if (r_cnt != CNT_W'(TIMEOUT_CYCLES))  r_cnt <= r_cnt + CNT_W'(1);
      if (w_ld_tens) r_tens <= bus.rx_data[3:0];
      if (w_ld_h)    r_hour <= w_val[4:0];
      if (w_ld_m)    r_min  <= w_val[5:0];
      if (w_ld_s)    r_sec  <= w_val[5:0];
      r_set_valid <= w_commit;
      if (w_commit) r_set_data <= {r_hour, r_min, r_sec, 7'd0};
      r_err <= w_bad || w_range || w_tmo_err;
      if (w_bad)          r_err_code <= 2'd1;
      else if (w_range)   r_err_code <= 2'd2;
      else if (w_tmo_err) r_err_code <= 2'd3;
    end
  end

  assign bus.o_set_valid = r_set_valid;
  assign bus.o_set_data  = r_set_data;
  assign bus.o_err       = r_err;
  assign bus.o_err_code  = r_err_code;
  assign bus.o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed command lines, a line-level reference
// model checked every cycle, and literal expectations for each scenario.
module tb_uart_cmd_parser;
  localparam int TMO = 50;
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A;

  logic clk, rst;
  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  int n_valid = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: tracks the line as "mode + character position".
  int          m_mode;   // 0 idle, 1 inside a command, 2 discarding
  int          m_pos;    // characters received after 'T'
  int          m_gap;    // idle cycles since the last byte of a command
  int          d[8];
  logic        exp_valid, exp_err;
  logic [23:0] exp_data;
  logic [1:0]  exp_code;

  task automatic model_err(input logic [1:0] c);
    exp_err  = 1'b1;
    exp_code = c;
    m_mode   = 2;
  endtask

  task automatic model_cmd_byte(input logic [7:0] b);
    int v, lim;
    if (m_pos == 8) begin
      if (b == CR || b == LF) begin
        exp_valid = 1'b1;
        exp_data  = 24'(((d[0]*10 + d[1]) * (2**19)) + ((d[3]*10 + d[4]) * (2**13))
                        + ((d[6]*10 + d[7]) * (2**7)));
        m_mode = 0;
      end else model_err(2'd1);
    end else if (m_pos == 2 || m_pos == 5) begin
      if (b != 8'h3A) model_err(2'd1);
    end else if (b < 8'h30 || b > 8'h39) begin
      model_err(2'd1);
    end else begin
      d[m_pos] = int'(b) - 48;
      if (m_pos == 1 || m_pos == 4 || m_pos == 7) begin
        v   = d[m_pos-1]*10 + d[m_pos];
        lim = (m_pos == 1) ? 24 : 60;
        if (v >= lim) model_err(2'd2);
      end
    end
    m_pos++;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_pos = 0; m_gap = 0;
      exp_valid = 1'b0; exp_err = 1'b0; exp_data = '0; exp_code = '0;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (bus.rx_done) begin
        m_gap = 0;
        case (m_mode)
          0: if (bus.rx_data == 8'h54) begin m_mode = 1; m_pos = 0; end
          1: model_cmd_byte(bus.rx_data);
          default: if (bus.rx_data == CR || bus.rx_data == LF) m_mode = 0;
        endcase
      end else if (m_mode != 0) begin
        if (m_gap == TMO) begin
          if (m_mode == 1) begin exp_err = 1'b1; exp_code = 2'd3; end
          m_mode = 0;
        end else m_gap++;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("set_valid", 32'(bus.o_set_valid), 32'(exp_valid));
      chk("set_data",  32'(bus.o_set_data),  32'(exp_data));
      chk("err",       32'(bus.o_err),       32'(exp_err));
      chk("err_code",  32'(bus.o_err_code),  32'(exp_code));
      chk("busy",      32'(bus.o_busy),      32'(m_mode != 0));
      chk("excl", 32'(bus.o_set_valid && bus.o_err), 32'd0);
      if (bus.o_set_valid) n_valid++;
      if (bus.o_err)       n_err++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int v0, e0;

  initial begin
    rst = 1'b1;
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_data",  32'(bus.o_set_data), 32'h0);
    chk("rst_busy",  32'(bus.o_busy),     32'h0);
    chk("rst_code",  32'(bus.o_err_code), 32'h0);

    // 12:34:56 with CR LF; the trailing LF is ignored in idle
    v0 = n_valid; e0 = n_err;
    send_str("T12:34:56"); send_byte(CR); send_byte(LF); idle(3);
    chk("s1_data",  32'(bus.o_set_data), 32'h645C00);
    chk("s1_nval",  32'(n_valid - v0),   32'd1);
    chk("s1_nerr",  32'(n_err - e0),     32'd0);
    chk("s1_busy",  32'(bus.o_busy),     32'd0);

    // hour 24 is out of range, rest of line discarded
    v0 = n_valid; e0 = n_err;
    send_str("T24:00:00"); send_byte(CR); idle(3);
    chk("s2_code",  32'(bus.o_err_code), 32'd2);
    chk("s2_nerr",  32'(n_err - e0),     32'd1);
    chk("s2_nval",  32'(n_valid - v0),   32'd0);
    chk("s2_data",  32'(bus.o_set_data), 32'h645C00);
    chk("s2_busy",  32'(bus.o_busy),     32'd0);

    // bad char, recovery on LF, then midnight
    v0 = n_valid; e0 = n_err;
    send_str("T1x"); idle(2);
    chk("s3_code",  32'(bus.o_err_code), 32'd1);
    chk("s3_busy",  32'(bus.o_busy),     32'd1);
    send_byte(LF); idle(1);
    chk("s3_idle",  32'(bus.o_busy),     32'd0);
    send_str("T00:00:00"); send_byte(LF); idle(3);
    chk("s3_data",  32'(bus.o_set_data), 32'h000000);
    chk("s3_nval",  32'(n_valid - v0),   32'd1);
    chk("s3_nerr",  32'(n_err - e0),     32'd1);

    // junk in idle ignored, then 23:59:59
    v0 = n_valid; e0 = n_err;
    send_str("14"); send_byte(CR); idle(2);
    send_str("T23:59:59"); send_byte(CR); idle(3);
    chk("s4_data",  32'(bus.o_set_data), 32'hBF7D80);
    chk("s4_nerr",  32'(n_err - e0),     32'd0);
    chk("s4_nval",  32'(n_valid - v0),   32'd1);

    // timeout: error exactly one cycle after the count reaches TMO
    e0 = n_err;
    send_str("T0"); idle(TMO);
    chk("to_early", 32'(bus.o_err),      32'd0);
    chk("to_busy",  32'(bus.o_busy),     32'd1);
    idle(1);
    chk("to_err",   32'(bus.o_err),      32'd1);
    chk("to_code",  32'(bus.o_err_code), 32'd3);
    chk("to_idle",  32'(bus.o_busy),     32'd0);
    chk("to_nerr",  32'(n_err - e0),     32'd1);

    // byte on the expiry cycle keeps the command alive
    v0 = n_valid; e0 = n_err;
    send_str("T0"); idle(TMO);
    send_byte("1"); idle(3);
    chk("tb_busy",  32'(bus.o_busy),     32'd1);
    send_str(":00:00"); send_byte(LF); idle(3);
    chk("tb_data",  32'(bus.o_set_data), 32'h080000);
    chk("tb_nerr",  32'(n_err - e0),     32'd0);
    chk("tb_nval",  32'(n_valid - v0),   32'd1);

    // reset mid-command, then a clean command
    send_str("T12:3");
    rst = 1'b1;
    #1;
    chk("mr_data",  32'(bus.o_set_data), 32'h0);
    chk("mr_busy",  32'(bus.o_busy),     32'h0);
    chk("mr_err",   32'(bus.o_err),      32'h0);
    chk("mr_code",  32'(bus.o_err_code), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);
    v0 = n_valid;
    send_str("T01:02:03"); send_byte(CR); idle(3);
    chk("mr_cmd",   32'(bus.o_set_data), 32'h084180);
    chk("mr_nval",  32'(n_valid - v0),   32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
